// File: rtl/bsg_axil_pkg.sv
// Shared AXI4-Lite definitions for the CSR responder and its helpers.
package bsg_axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  localparam int unsigned axil_prot_width_lp = 3;

endpackage

// File: rtl/bsg_axil_csr_responder_if.sv
// AXI4-Lite bus bundle between an initiator (master) and the CSR responder (slave).
interface bsg_axil_csr_responder_if
  import bsg_axil_pkg::*;
  #(parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    localparam int strb_width_lp = data_width_p / 8);

  logic [addr_width_p-1:0]       awaddr_i;
  logic [axil_prot_width_lp-1:0] awprot_i;
  logic                          awvalid_i;
  logic                          awready_o;
  logic [data_width_p-1:0]       wdata_i;
  logic [strb_width_lp-1:0]      wstrb_i;
  logic                          wvalid_i;
  logic                          wready_o;
  logic [1:0]                    bresp_o;
  logic                          bvalid_o;
  logic                          bready_i;
  logic [addr_width_p-1:0]       araddr_i;
  logic [axil_prot_width_lp-1:0] arprot_i;
  logic                          arvalid_i;
  logic                          arready_o;
  logic [data_width_p-1:0]       rdata_o;
  logic [1:0]                    rresp_o;
  logic                          rvalid_o;
  logic                          rready_i;

  modport slave (
    input  awaddr_i, awprot_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arprot_i, arvalid_i, rready_i,
    output awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o, rresp_o, rvalid_o
  );

  modport master (
    output awaddr_i, awprot_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arprot_i, arvalid_i, rready_i,
    input  awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o, rresp_o, rvalid_o
  );

endinterface

// File: rtl/bsg_axil_csr_decode.sv
// Combinational byte-address to CSR-index decode with range check.
module bsg_axil_csr_decode
  #(parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int num_regs_p = 4,
    parameter longint unsigned base_addr_p = 0,
    localparam int strb_width_lp = data_width_p / 8,
    localparam int lg_strb_lp = $clog2(strb_width_lp),
    localparam int idx_width_lp = (num_regs_p > 1) ? $clog2(num_regs_p) : 1)
  (input  logic [addr_width_p-1:0] addr_i,
   output logic [idx_width_lp-1:0] idx_o,
   output logic                    in_range_o);

  localparam logic [addr_width_p-1:0] base_lp = addr_width_p'(base_addr_p);

  logic [addr_width_p:0]   off;
  logic [addr_width_p-1:0] off_words;

  // The extra top bit of off is the borrow: set when addr is below the base.
  always_comb begin
    off        = {1'b0, addr_i} - {1'b0, base_lp};
    off_words  = off[addr_width_p-1:0] >> lg_strb_lp;
    in_range_o = ~off[addr_width_p] && (off_words < addr_width_p'(num_regs_p));
    idx_o      = off_words[idx_width_lp-1:0];
  end

endmodule

// File: rtl/bsg_axil_csr_responder.sv
// AXI4-Lite responder exposing a bank of byte-writable CSRs to PL logic.
module bsg_axil_csr_responder
  import bsg_axil_pkg::*;
  #(parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int num_regs_p = 4,
    parameter longint unsigned base_addr_p = 0,
    localparam int strb_width_lp = data_width_p / 8,
    localparam int idx_width_lp = (num_regs_p > 1) ? $clog2(num_regs_p) : 1)
  (input  logic                               clk_i,
   input  logic                               reset_i,
   bsg_axil_csr_responder_if.slave            axil_s,
   output logic [num_regs_p*data_width_p-1:0] csr_o,
   output logic [num_regs_p-1:0]              csr_w_o);

  logic                     aw_full_q, aw_full_d;
  logic [addr_width_p-1:0]  aw_addr_q, aw_addr_d;
  logic                     w_full_q, w_full_d;
  logic [data_width_p-1:0]  w_data_q, w_data_d;
  logic [strb_width_lp-1:0] w_strb_q, w_strb_d;
  logic                     bvalid_q, bvalid_d;
  axil_resp_e               bresp_q, bresp_d;
  logic                     rvalid_q, rvalid_d;
  axil_resp_e               rresp_q, rresp_d;
  logic [data_width_p-1:0]  rdata_q, rdata_d;
  logic [data_width_p-1:0]  csr_q [num_regs_p];
  logic [data_width_p-1:0]  csr_d [num_regs_p];

  logic [idx_width_lp-1:0]  w_idx, r_idx;
  logic                     w_in_range, r_in_range;
  logic                     aw_hs, w_hs, ar_hs, commit;
  logic [data_width_p-1:0]  rd_word;

  logic unused_prot;
  assign unused_prot = ^{axil_s.awprot_i, axil_s.arprot_i};

  bsg_axil_csr_decode #(
    .addr_width_p(addr_width_p), .data_width_p(data_width_p),
    .num_regs_p(num_regs_p), .base_addr_p(base_addr_p)
  ) wr_decode (
    .addr_i(aw_addr_q), .idx_o(w_idx), .in_range_o(w_in_range)
  );

  bsg_axil_csr_decode #(
    .addr_width_p(addr_width_p), .data_width_p(data_width_p),
    .num_regs_p(num_regs_p), .base_addr_p(base_addr_p)
  ) rd_decode (
    .addr_i(axil_s.araddr_i), .idx_o(r_idx), .in_range_o(r_in_range)
  );

  assign axil_s.awready_o = ~aw_full_q;
  assign axil_s.wready_o  = ~w_full_q;
  assign axil_s.arready_o = ~rvalid_q;
  assign axil_s.bvalid_o  = bvalid_q;
  assign axil_s.bresp_o   = bresp_q;
  assign axil_s.rvalid_o  = rvalid_q;
  assign axil_s.rresp_o   = rresp_q;
  assign axil_s.rdata_o   = rdata_q;

  always_comb begin
    aw_hs  = axil_s.awvalid_i & ~aw_full_q;
    w_hs   = axil_s.wvalid_i & ~w_full_q;
    ar_hs  = axil_s.arvalid_i & ~rvalid_q;
    commit = aw_full_q & w_full_q & ~bvalid_q;

    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    csr_w_o   = '0;
    for (int k = 0; k < num_regs_p; k++) csr_d[k] = csr_q[k];

    // Holding registers are never ready while full, so commit and capture cannot collide.
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = axil_s.awaddr_i;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = axil_s.wdata_i;
      w_strb_d = axil_s.wstrb_i;
    end

    if (bvalid_q && axil_s.bready_i) begin
      bvalid_d = 1'b0;
      bresp_d  = OKAY;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (w_in_range) bresp_d = OKAY;
      else            bresp_d = SLVERR;
      for (int k = 0; k < num_regs_p; k++) begin
        csr_w_o[k] = w_in_range && (w_idx == idx_width_lp'(k));
        if (csr_w_o[k]) begin
          for (int b = 0; b < strb_width_lp; b++) begin
            if (w_strb_q[b]) csr_d[k][8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
      end
    end
  end

  // Reads sample the pre-commit CSR value, so a same-cycle write is not visible.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < num_regs_p; k++) begin
      if (r_in_range && (r_idx == idx_width_lp'(k))) rd_word = csr_q[k];
    end

    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && axil_s.rready_i) begin
      rvalid_d = 1'b0;
      rresp_d  = OKAY;
      rdata_d  = '0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      if (r_in_range) rresp_d = OKAY;
      else            rresp_d = SLVERR;
    end
  end

  always_comb begin
    for (int k = 0; k < num_regs_p; k++) csr_o[k*data_width_p +: data_width_p] = csr_q[k];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      for (int k = 0; k < num_regs_p; k++) csr_q[k] <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      for (int k = 0; k < num_regs_p; k++) csr_q[k] <= csr_d[k];
    end
  end

  // Holding-register payloads are qualified by their full flags.
  always_ff @(posedge clk_i) begin
    aw_addr_q <= aw_addr_d;
    w_data_q  <= w_data_d;
    w_strb_q  <= w_strb_d;
  end

endmodule

// File: tb/tb_bsg_axil_csr_responder.sv
// Scoreboard bench for the AXI4-Lite CSR responder using directed vectors.
module tb_bsg_axil_csr_responder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bsg_axil_csr_responder_if #(.addr_width_p(AW), .data_width_p(DW)) ifc ();
  logic [NR*DW-1:0] csr;
  logic [NR-1:0]    csr_w;

  bsg_axil_csr_responder #(
    .addr_width_p(AW), .data_width_p(DW), .num_regs_p(NR), .base_addr_p(0)
  ) dut (
    .clk_i(clk), .reset_i(reset), .axil_s(ifc), .csr_o(csr), .csr_w_o(csr_w)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
  } r_exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  b_q[$];
  r_exp_t      r_q[$];
  int          pulse_q[$];
  r_exp_t      mon_r;
  logic [NR*DW-1:0] snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation each time the DUT presents a response or pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (ifc.bvalid_o && ifc.bready_i) begin
        if (b_q.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", ifc.bresp_o, b_q.pop_front());
      end
      if (ifc.rvalid_o && ifc.rready_i) begin
        if (r_q.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          mon_r = r_q.pop_front();
          chk("rdata", ifc.rdata_o, mon_r.d);
          chk("rresp", ifc.rresp_o, mon_r.r);
        end
      end
      if (csr_w != '0) begin
        if (pulse_q.size() == 0) chk("csr_w_unexpected", csr_w, 0);
        else chk("csr_w", csr_w, 4'(1) << pulse_q.pop_front());
      end
    end
  end

  task automatic expect_write(input logic [31:0] a);
    if (a < 32'(NR*4)) begin
      pulse_q.push_back(int'(a >> 2));
      b_q.push_back(2'b00);
    end else begin
      b_q.push_back(2'b10);
    end
  endtask

  task automatic write_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_done, w_done, aw_hs, w_hs;
    aw_done = 0; w_done = 0;
    ifc.awaddr_i = a; ifc.awvalid_i = 1'b1;
    ifc.wdata_i = d; ifc.wstrb_i = s; ifc.wvalid_i = 1'b1;
    for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      aw_hs = ifc.awvalid_i && ifc.awready_o;
      w_hs  = ifc.wvalid_i && ifc.wready_o;
      @(posedge clk); #1;
      if (aw_hs) begin ifc.awvalid_i = 1'b0; aw_done = 1; end
      if (w_hs)  begin ifc.wvalid_i = 1'b0;  w_done = 1;  end
    end
    ifc.awvalid_i = 1'b0; ifc.wvalid_i = 1'b0;
    if (!(aw_done && w_done)) chk("write_handshake_timeout", 0, 1);
  endtask

  task automatic send_aw(input logic [31:0] a);
    bit done;
    done = 0;
    ifc.awaddr_i = a; ifc.awvalid_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); done = ifc.awready_o;
      @(posedge clk); #1;
    end
    ifc.awvalid_i = 1'b0;
    if (!done) chk("aw_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit done;
    done = 0;
    ifc.wdata_i = d; ifc.wstrb_i = s; ifc.wvalid_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); done = ifc.wready_o;
      @(posedge clk); #1;
    end
    ifc.wvalid_i = 1'b0;
    if (!done) chk("w_timeout", 0, 1);
  endtask

  task automatic ar_only(input logic [31:0] a);
    bit done;
    done = 0;
    ifc.araddr_i = a; ifc.arvalid_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); done = ifc.arready_o;
      @(posedge clk); #1;
    end
    ifc.arvalid_i = 1'b0;
    if (!done) chk("ar_timeout", 0, 1);
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    r_exp_t e;
    e.d = d; e.r = r;
    r_q.push_back(e);
    ar_only(a);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (b_q.size() + r_q.size() + pulse_q.size()) != 0; i++)
      @(posedge clk);
    #1;
    chk("queues_drained", 64'(b_q.size() + r_q.size() + pulse_q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ifc.awaddr_i = '0; ifc.awprot_i = '0; ifc.awvalid_i = 1'b0;
    ifc.wdata_i = '0; ifc.wstrb_i = '0; ifc.wvalid_i = 1'b0;
    ifc.bready_i = 1'b1;
    ifc.araddr_i = '0; ifc.arprot_i = '0; ifc.arvalid_i = 1'b0;
    ifc.rready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_awready", ifc.awready_o, 1);
    chk("rst_wready", ifc.wready_o, 1);
    chk("rst_arready", ifc.arready_o, 1);
    chk("rst_bvalid", ifc.bvalid_o, 0);
    chk("rst_rvalid", ifc.rvalid_o, 0);
    chk("rst_bresp", ifc.bresp_o, 0);
    chk("rst_rresp", ifc.rresp_o, 0);
    chk("rst_rdata", ifc.rdata_o, 0);
    chk("rst_csr_w", csr_w, 0);
    chk("rst_csr", csr, 0);

    for (int a = 0; a < 16; a += 4) send_ar(32'(a), 32'h0, 2'b00);
    wait_idle();

    expect_write(32'h4);
    write_both(32'h4, 32'hDEADBEEF, 4'hF);
    wait_idle();
    send_ar(32'h4, 32'hDEADBEEF, 2'b00);
    wait_idle();
    chk("csr1_value", csr[1*DW +: DW], 32'hDEADBEEF);

    expect_write(32'h8);
    write_both(32'h8, 32'hFFFFFFFF, 4'hF);
    wait_idle();
    send_w(32'h11223344, 4'h5);
    repeat (3) @(posedge clk);
    #1;
    expect_write(32'h8);
    send_aw(32'h8);
    chk("b_not_early", ifc.bvalid_o, 0);
    @(posedge clk); #1;
    chk("b_latency", ifc.bvalid_o, 1);
    wait_idle();
    send_ar(32'h8, 32'hFF22FF44, 2'b00);
    wait_idle();

    snap = csr;
    expect_write(32'h40);
    write_both(32'h40, 32'hCAFEF00D, 4'hF);
    send_ar(32'h40, 32'h0, 2'b10);
    wait_idle();
    chk("oor_csr_unchanged", csr, snap);

    ifc.bready_i = 1'b0;
    expect_write(32'hC);
    write_both(32'hC, 32'hA5A5A5A5, 4'hF);
    for (int i = 0; i < 20 && !ifc.bvalid_o; i++) begin
      @(posedge clk); #1;
    end
    expect_write(32'h0);
    write_both(32'h0, 32'h5A5A5A5A, 4'h3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_bvalid", ifc.bvalid_o, 1);
      chk("hold_no_pulse", csr_w, 0);
      chk("hold_csr0", csr[0 +: DW], 0);
    end
    @(posedge clk); #1;
    ifc.bready_i = 1'b1;
    wait_idle();
    send_ar(32'h0, 32'h00005A5A, 2'b00);
    send_ar(32'hC, 32'hA5A5A5A5, 2'b00);
    wait_idle();

    expect_write(32'h0);
    write_both(32'h0, 32'h1, 4'hF);
    wait_idle();
    expect_write(32'h0);
    fork
      write_both(32'h0, 32'h2, 4'hF);
      begin
        @(posedge clk); #1;
        send_ar(32'h0, 32'h1, 2'b00);
      end
    join
    wait_idle();
    send_ar(32'h0, 32'h2, 2'b00);
    wait_idle();

    ifc.rready_i = 1'b0;
    ar_only(32'h4);
    chk("rvalid_pending", ifc.rvalid_o, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rvalid", ifc.rvalid_o, 0);
    chk("midrst_rdata", ifc.rdata_o, 0);
    chk("midrst_csr", csr, 0);
    chk("midrst_arready", ifc.arready_o, 1);
    reset = 1'b0;
    ifc.rready_i = 1'b1;
    send_ar(32'h4, 32'h0, 2'b00);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
